bit_collector: RTL and testbench

BIT_COLLECTOR -- requirements
Module: bit_collector

---
 rtl/bit_collector_if.sv | 26 ++
 rtl/bit_collector.sv | 104 ++++++++++
 tb/tb_bit_collector.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bit_collector_if.sv
// Handshake bundle for bit_collector: serial pixel input side and the
// assembled-word output slot with its consumer handshake.
interface bit_collector_if #(
  parameter int WIDTH = 16
);
  logic             d;
  logic             start;
  logic             enable;
  logic [3:0]       mult;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             q_ready;
  logic             overrun;

  // Handshake: a word transfers on every rising edge where q_valid && q_ready;
  // q holds steady while q_valid=1 and q_ready=0, and q_ready may be high at any time.
  modport master (
    input  d, start, enable, mult, q_ready,
    output q, q_valid, overrun
  );

  modport slave (
    output d, start, enable, mult, q_ready,
    input  q, q_valid, overrun
  );
endinterface

// File: rtl/bit_collector.sv
// Serial-to-parallel pixel collector: each pixel spans mult+1 enabled cycles,
// WIDTH samples (MSB first) form one word offered through a single-entry slot.
module bit_collector #(
  parameter int WIDTH = 16,
  localparam int BW = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  bit_collector_if.master       bus,
  output logic [3:0]            dbg_rcnt,
  output logic [BW-1:0]         dbg_bcnt
);

  logic [3:0]       rcnt_q, rcnt_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-2:0] sr_shift;
  logic             word_done;
  logic             slot_free;

  generate
    if (WIDTH > 2) begin : g_wide
      assign sr_shift = {sr_q[WIDTH-3:0], bus.d};
    end else begin : g_narrow
      assign sr_shift = bus.d;
    end
  endgenerate

  always_comb begin
    rcnt_d    = rcnt_q;
    bcnt_d    = bcnt_q;
    sr_d      = sr_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    overrun_d = overrun_q;
    word_done = 1'b0;
    slot_free = !q_valid_q || bus.q_ready;

    if (bus.start) begin
      rcnt_d    = 4'd0;
      bcnt_d    = '0;
      sr_d      = '0;
      overrun_d = 1'b0;
    end else if (bus.enable) begin
      // >= rather than == so that lowering mult mid-pixel samples at once.
      if (rcnt_q < bus.mult) begin
        rcnt_d = rcnt_q + 4'd1;
      end else begin
        rcnt_d = 4'd0;
        if (bcnt_q == BW'(WIDTH - 1)) begin
          word_done = 1'b1;
          bcnt_d    = '0;
          sr_d      = '0;
        end else begin
          sr_d   = sr_shift;
          bcnt_d = bcnt_q + BW'(1);
        end
      end
    end

    // The consumer handshake applies regardless of start.
    if (q_valid_q && bus.q_ready) begin
      q_valid_d = 1'b0;
    end

    if (word_done) begin
      if (slot_free) begin
        q_d       = {sr_q, bus.d};
        q_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt_q    <= 4'd0;
      bcnt_q    <= '0;
      sr_q      <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rcnt_q    <= rcnt_d;
      bcnt_q    <= bcnt_d;
      sr_q      <= sr_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.q_valid = q_valid_q;
  assign bus.overrun = overrun_q;
  assign dbg_rcnt    = rcnt_q;
  assign dbg_bcnt    = bcnt_q;

endmodule

// File: tb/tb_bit_collector.sv
// Bench for bit_collector: directed scenarios plus a scoreboard that checks
// every word accepted by the consumer against the expected queue.
module tb_bit_collector;
  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic [3:0]   dbg_rcnt;
  logic [3:0]   dbg_bcnt;
  logic [W-1:0] exp_q[$];
  int           n_checks;
  int           n_fail;

  bit_collector_if #(.WIDTH(W)) bus ();

  bit_collector #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .dbg_rcnt (dbg_rcnt),
    .dbg_bcnt (dbg_bcnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  // scoreboard: every accepted word must match the head of exp_q
  always @(negedge clk) begin
    if (!reset && bus.q_valid === 1'b1 && bus.q_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got q=%h, required no word", bus.q);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (bus.q !== e) begin
          n_fail++;
          $display("FAIL sb_word: got q=%h, required %h", bus.q, e);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input int reps, input bit push);
    if (push) exp_q.push_back(w);
    for (int i = W - 1; i >= 0; i--) begin
      bus.d      = w[i];
      bus.enable = 1'b1;
      for (int r = 0; r < reps; r++) tick();
    end
    bus.enable = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_checks++; if (bus.q !== 16'h0000) begin n_fail++; $display("FAIL reset_q: got %h, required 0000", bus.q); end
    n_checks++; if (bus.q_valid !== 1'b0) begin n_fail++; $display("FAIL reset_q_valid: got %b, required 0", bus.q_valid); end
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b, required 0", bus.overrun); end
    n_checks++; if (dbg_bcnt !== 4'd0) begin n_fail++; $display("FAIL reset_bcnt: got %0d, required 0", dbg_bcnt); end
  endtask

  task automatic test_basic();
    bus.q_ready = 1'b1;
    bus.mult    = 4'd0;
    pulse_start();
    exp_q.push_back(16'hA5C3);
    for (int i = W - 1; i >= 0; i--) begin
      bus.d      = 16'hA5C3 >> i;
      bus.enable = 1'b1;
      if (i == 0) begin
        n_checks++; if (bus.q_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b, required 0", bus.q_valid); end
      end
      tick();
    end
    bus.enable = 1'b0;
    n_checks++; if (bus.q_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b, required 1", bus.q_valid); end
    n_checks++; if (bus.q !== 16'hA5C3) begin n_fail++; $display("FAIL basic_q: got %h, required a5c3", bus.q); end
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL basic_overrun: got %b, required 0", bus.overrun); end
    tick();
  endtask

  task automatic test_mult();
    bus.q_ready = 1'b1;
    bus.mult    = 4'd3;
    pulse_start();
    send_word(16'h8001, 4, 1'b1);
    n_checks++; if (bus.q_valid !== 1'b1 || bus.q !== 16'h8001) begin n_fail++; $display("FAIL mult_q: got %h/%b, required 8001/1", bus.q, bus.q_valid); end
    tick();
    pulse_start();
    exp_q.push_back(16'h8001);
    for (int i = W - 1; i >= 0; i--) begin
      bus.d = 16'h8001 >> i;
      for (int c = 0; c < 8; c++) begin
        bus.enable = (c % 2 == 0);
        tick();
      end
    end
    bus.enable = 1'b0;
    n_checks++; if (bus.q !== 16'h8001) begin n_fail++; $display("FAIL mult_toggle_q: got %h, required 8001", bus.q); end
    tick();
  endtask

  task automatic test_overrun();
    bus.q_ready = 1'b0;
    bus.mult    = 4'd0;
    pulse_start();
    send_word(16'h1234, 1, 1'b0);
    n_checks++; if (bus.q_valid !== 1'b1 || bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first: got valid=%b overrun=%b, required 1/0", bus.q_valid, bus.overrun); end
    send_word(16'hFFFF, 1, 1'b0);
    n_checks++; if (bus.q !== 16'h1234) begin n_fail++; $display("FAIL ovr_hold_q: got %h, required 1234", bus.q); end
    n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b, required 1", bus.overrun); end
    pulse_start();
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_start_clear: got %b, required 0", bus.overrun); end
    n_checks++; if (bus.q_valid !== 1'b1 || bus.q !== 16'h1234) begin n_fail++; $display("FAIL ovr_start_keep: got %h/%b, required 1234/1", bus.q, bus.q_valid); end
    exp_q.push_back(16'h1234);
    bus.q_ready = 1'b1;
    tick();
    n_checks++; if (bus.q_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain: got %b, required 0", bus.q_valid); end
  endtask

  task automatic test_back_to_back();
    bus.q_ready = 1'b0;
    bus.mult    = 4'd0;
    pulse_start();
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    send_word(16'h1111, 1, 1'b0);
    for (int i = W - 1; i >= 0; i--) begin
      bus.d       = 16'h2222 >> i;
      bus.enable  = 1'b1;
      bus.q_ready = (i == 0);
      tick();
    end
    bus.enable = 1'b0;
    n_checks++; if (bus.q !== 16'h2222 || bus.q_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_q: got %h/%b, required 2222/1", bus.q, bus.q_valid); end
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b, required 0", bus.overrun); end
    tick();
    n_checks++; if (bus.q_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b, required 0", bus.q_valid); end
  endtask

  task automatic test_start_realign();
    bus.q_ready = 1'b1;
    bus.mult    = 4'd0;
    pulse_start();
    bus.d      = 1'b1;
    bus.enable = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    bus.enable = 1'b0;
    pulse_start();
    send_word(16'h00FF, 1, 1'b1);
    n_checks++; if (bus.q !== 16'h00FF) begin n_fail++; $display("FAIL realign_q: got %h, required 00ff", bus.q); end
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL realign_overrun: got %b, required 0", bus.overrun); end
    tick();
    bus.d      = 1'b1;
    bus.enable = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    bus.enable = 1'b0;
    n_checks++; if (bus.q !== 16'h0000 || bus.q_valid !== 1'b0 || bus.overrun !== 1'b0) begin n_fail++; $display("FAIL midword_reset: got %h/%b/%b, required 0000/0/0", bus.q, bus.q_valid, bus.overrun); end
    n_checks++; if (dbg_bcnt !== 4'd0 || dbg_rcnt !== 4'd0) begin n_fail++; $display("FAIL midword_reset_cnt: got bcnt=%0d rcnt=%0d, required 0/0", dbg_bcnt, dbg_rcnt); end
  endtask

  task automatic test_start_vs_complete();
    bus.q_ready = 1'b1;
    bus.mult    = 4'd0;
    pulse_start();
    for (int i = W - 1; i >= 0; i--) begin
      bus.d      = 16'hBEEF >> i;
      bus.enable = 1'b1;
      bus.start  = (i == 0);
      tick();
    end
    bus.start  = 1'b0;
    bus.enable = 1'b0;
    n_checks++; if (bus.q_valid !== 1'b0 || bus.overrun !== 1'b0) begin n_fail++; $display("FAIL start_wins: got valid=%b overrun=%b, required 0/0", bus.q_valid, bus.overrun); end
    n_checks++; if (dbg_bcnt !== 4'd0) begin n_fail++; $display("FAIL start_wins_bcnt: got %0d, required 0", dbg_bcnt); end
  endtask

  task automatic test_mult_change();
    bus.q_ready = 1'b1;
    bus.mult    = 4'd7;
    pulse_start();
    bus.d      = 1'b1;
    bus.enable = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (dbg_rcnt !== 4'd5 || dbg_bcnt !== 4'd0) begin n_fail++; $display("FAIL mchg_pre: got rcnt=%0d bcnt=%0d, required 5/0", dbg_rcnt, dbg_bcnt); end
    bus.mult = 4'd2;
    tick();
    n_checks++; if (dbg_rcnt !== 4'd0 || dbg_bcnt !== 4'd1) begin n_fail++; $display("FAIL mchg_sample: got rcnt=%0d bcnt=%0d, required 0/1", dbg_rcnt, dbg_bcnt); end
    tick();
    tick();
    n_checks++; if (dbg_bcnt !== 4'd1) begin n_fail++; $display("FAIL mchg_hold: got bcnt=%0d, required 1", dbg_bcnt); end
    tick();
    n_checks++; if (dbg_bcnt !== 4'd2 || dbg_rcnt !== 4'd0) begin n_fail++; $display("FAIL mchg_period: got rcnt=%0d bcnt=%0d, required 0/2", dbg_rcnt, dbg_bcnt); end
    bus.enable = 1'b0;
    pulse_start();
  endtask

  task automatic test_random();
    bus.q_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 6; k++) begin
      logic [W-1:0] w;
      int m;
      w        = W'($urandom_range(0, 65535));
      m        = $urandom_range(0, 3);
      bus.mult = 4'(m);
      send_word(w, m + 1, 1'b1);
    end
    tick();
    tick();
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    bus.d       = 1'b0;
    bus.start   = 1'b0;
    bus.enable  = 1'b0;
    bus.mult    = 4'd0;
    bus.q_ready = 1'b0;
    test_reset();
    test_basic();
    test_mult();
    test_overrun();
    test_back_to_back();
    test_start_realign();
    test_start_vs_complete();
    test_mult_change();
    test_random();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending words, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
